// File: rtl/ip_codma_bus_responder.sv
// Bus-side responder for the CODMA master bus. It serves one request at a time,
// checks that the request is legal, and grants after a programmable delay.
// After the grant it streams 64-bit read beats out of its internal word memory,
// or accepts 64-bit write beats into that memory.
// A backdoor port preloads and inspects the memory.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for req_i; latches the request and checks it
// DELAY    | grant delay down-counter running; terminal count 1 -> GRANT
// GRANT    | one-cycle grant pulse
// RD_BEATS | one read beat per cycle, back-to-back, until the last beat
// WR_BEATS | one memory write per cycle with write_valid_i; stalls allowed
// ERR      | one-cycle error pulse for an illegal request
module ip_codma_bus_responder #(
  parameter int MEM_WORDS   = 256,
  parameter int GRANT_DELAY = 2,
  parameter int ADDR_W      = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         req_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [3:0]                   size_i,
  input  logic                         write_i,
  input  logic                         write_valid_i,
  input  logic [63:0]                  write_data_i,
  output logic                         grant_o,
  output logic                         read_valid_o,
  output logic [63:0]                  read_data_o,
  output logic                         error_o,
  output logic                         busy_o,
  output logic [15:0]                  txn_count_o,
  input  logic                         bd_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_addr_i,
  input  logic [63:0]                  bd_wdata_i,
  output logic [63:0]                  bd_rdata_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int DLY_W = (GRANT_DELAY < 2) ? 1 : $clog2(GRANT_DELAY + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_GRANT,
    ST_RD_BEATS,
    ST_WR_BEATS,
    ST_ERR
  } state_t;

  state_t state_q, state_d;

  logic [63:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] base_q;
  logic [1:0]       last_q;
  logic             write_q;
  logic [1:0]       beat_idx_q;
  logic [DLY_W-1:0] dly_cnt_q;
  logic [63:0]      rd_data_q;
  logic [15:0]      txn_q;

  logic             accept;
  logic             req_bad;
  logic             dly_load;
  logic             dly_dec;
  logic             beat_inc;
  logic             rd_load;
  logic [1:0]       rd_idx;
  logic             wr_en;
  logic             txn_done;
  logic [2:0]       beats_in;
  logic [ADDR_W:0]  last_word;

  // Burst code to beat count; 0 marks an unsupported code.
  function automatic logic [2:0] burst_beats(input logic [3:0] size);
    case (size)
      4'd3:    burst_beats = 3'd1;
      4'd8:    burst_beats = 3'd2;
      4'd9:    burst_beats = 3'd4;
      default: burst_beats = 3'd0;
    endcase
  endfunction

  // Request legality: supported burst, 8-byte aligned, burst fits in memory.
  always_comb begin
    beats_in  = burst_beats(size_i);
    last_word = (ADDR_W+1)'(addr_i >> 3) + (ADDR_W+1)'(beats_in) - (ADDR_W+1)'(1);
    req_bad   = (beats_in == 3'd0) || (addr_i[2:0] != 3'd0) ||
                (last_word >= (ADDR_W+1)'(MEM_WORDS));
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode, output pulses and datapath strobes.
  // A low req_i in any active bus state aborts: no beat, no write, no count.
  always_comb begin
    state_d      = state_q;
    grant_o      = 1'b0;
    error_o      = 1'b0;
    read_valid_o = 1'b0;
    busy_o       = (state_q != ST_IDLE);
    accept       = 1'b0;
    dly_load     = 1'b0;
    dly_dec      = 1'b0;
    beat_inc     = 1'b0;
    rd_load      = 1'b0;
    rd_idx       = 2'd0;
    wr_en        = 1'b0;
    txn_done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          accept = 1'b1;
          if (req_bad) begin
            state_d = ST_ERR;
          end else if (GRANT_DELAY == 0) begin
            state_d = ST_GRANT;
          end else begin
            state_d  = ST_DELAY;
            dly_load = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        if (!req_i) begin
          state_d = ST_IDLE;
        end else begin
          dly_dec = 1'b1;
          if (dly_cnt_q == DLY_W'(1)) state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        grant_o = 1'b1;
        if (!req_i) begin
          state_d = ST_IDLE;
        end else if (write_q) begin
          state_d = ST_WR_BEATS;
        end else begin
          state_d = ST_RD_BEATS;
          rd_load = 1'b1;
          rd_idx  = 2'd0;
        end
      end
      ST_RD_BEATS: begin
        if (!req_i) begin
          state_d = ST_IDLE;
        end else begin
          read_valid_o = 1'b1;
          beat_inc     = 1'b1;
          if (beat_idx_q == last_q) begin
            state_d  = ST_IDLE;
            txn_done = 1'b1;
          end else begin
            rd_load = 1'b1;
            rd_idx  = beat_idx_q + 2'd1;
          end
        end
      end
      ST_WR_BEATS: begin
        if (!req_i) begin
          state_d = ST_IDLE;
        end else if (write_valid_i) begin
          wr_en    = 1'b1;
          beat_inc = 1'b1;
          if (beat_idx_q == last_q) begin
            state_d  = ST_IDLE;
            txn_done = 1'b1;
          end
        end
      end
      ST_ERR: begin
        error_o = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, beat index, grant-delay down-counter, read data, txn counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      base_q     <= '0;
      last_q     <= '0;
      write_q    <= 1'b0;
      beat_idx_q <= '0;
      dly_cnt_q  <= '0;
      rd_data_q  <= '0;
      txn_q      <= '0;
    end else begin
      if (accept) begin
        base_q  <= addr_i[3 +: IDX_W];
        last_q  <= 2'(burst_beats(size_i) - 3'd1);
        write_q <= write_i;
      end
      if (state_q == ST_IDLE) beat_idx_q <= '0;
      else if (beat_inc)      beat_idx_q <= beat_idx_q + 2'd1;
      if (dly_load)     dly_cnt_q <= DLY_W'(GRANT_DELAY);
      else if (dly_dec) dly_cnt_q <= dly_cnt_q - DLY_W'(1);
      if (rd_load) rd_data_q <= mem[base_q + IDX_W'(rd_idx)];
      if (txn_done) txn_q <= txn_q + 16'd1;
    end
  end

  // Memory is not reset. The bus write is issued last so it wins a same-word
  // collision with the backdoor; a reset cycle suppresses the bus write.
  always_ff @(posedge clk_i) begin
    if (bd_we_i) mem[bd_addr_i] <= bd_wdata_i;
    if (wr_en && !reset_i) mem[base_q + IDX_W'(beat_idx_q)] <= write_data_i;
  end

  assign read_data_o = rd_data_q;
  assign txn_count_o = txn_q;
  assign bd_rdata_o  = mem[bd_addr_i];

endmodule

// File: tb/tb_ip_codma_bus_responder.sv
// Bench for ip_codma_bus_responder. Read beats are predicted into a queue
// and checked by a monitor. The stimulus process checks grant/error timing,
// counters, and memory contents through the backdoor port.
// A second instance with GRANT_DELAY=0 covers the zero-delay grant.
module tb_ip_codma_bus_responder;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_i, req0;
  logic [31:0] addr_i;
  logic [3:0]  size_i;
  logic        write_i;
  logic        write_valid_i;
  logic [63:0] write_data_i;
  logic        bd_we_i;
  logic [7:0]  bd_addr_i;
  logic [63:0] bd_wdata_i;

  logic        grant_o, read_valid_o, error_o, busy_o;
  logic [63:0] read_data_o, bd_rdata_o;
  logic [15:0] txn_count_o;

  logic        grant0, read_valid0, error0, busy0;
  logic [63:0] read_data0, bd_rdata0;
  logic [15:0] txn0;

  int n_cmp = 0;
  int n_err = 0;
  int grant_cnt = 0;
  int err_cnt = 0;
  int rv_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  ip_codma_bus_responder #(.MEM_WORDS(256), .GRANT_DELAY(2), .ADDR_W(32)) u_dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .addr_i(addr_i),
    .size_i(size_i), .write_i(write_i), .write_valid_i(write_valid_i),
    .write_data_i(write_data_i), .grant_o(grant_o), .read_valid_o(read_valid_o),
    .read_data_o(read_data_o), .error_o(error_o), .busy_o(busy_o),
    .txn_count_o(txn_count_o), .bd_we_i(bd_we_i), .bd_addr_i(bd_addr_i),
    .bd_wdata_i(bd_wdata_i), .bd_rdata_o(bd_rdata_o)
  );

  ip_codma_bus_responder #(.MEM_WORDS(256), .GRANT_DELAY(0), .ADDR_W(32)) u_dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req0), .addr_i(addr_i),
    .size_i(size_i), .write_i(write_i), .write_valid_i(write_valid_i),
    .write_data_i(write_data_i), .grant_o(grant0), .read_valid_o(read_valid0),
    .read_data_o(read_data0), .error_o(error0), .busy_o(busy0),
    .txn_count_o(txn0), .bd_we_i(bd_we_i), .bd_addr_i(bd_addr_i),
    .bd_wdata_i(bd_wdata_i), .bd_rdata_o(bd_rdata0)
  );

  // Monitor: pops an expected beat for every read_valid_o, counts pulses.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (grant_o) grant_cnt++;
      if (error_o) err_cnt++;
      if (read_valid_o) begin
        rv_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL read_beat: got 0x%0h with no beat expected", read_data_o);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if (read_data_o !== e) begin
            n_err++;
            $display("FAIL read_beat: got 0x%0h expected 0x%0h", read_data_o, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [63:0] d);
    bd_we_i = 1'b1; bd_addr_i = a; bd_wdata_i = d;
    tick();
    bd_we_i = 1'b0;
  endtask

  task automatic bd_check(input string name, input logic [7:0] a, input logic [63:0] exp);
    bd_addr_i = a;
    #1;
    check(name, bd_rdata_o, exp);
  endtask

  task automatic request(input logic [31:0] a, input logic [3:0] s, input logic w);
    req_i = 1'b1; addr_i = a; size_i = s; write_i = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Illegal request vectors: {addr, size}
  logic [31:0] bad_addr [3] = '{32'h0, 32'h4, 32'h7F8};
  logic [3:0]  bad_size [3] = '{4'd5, 4'd3, 4'd9};

  initial begin
    int g0, e0, r0;
    reset_i = 1'b1; req_i = 1'b0; req0 = 1'b0; addr_i = '0; size_i = '0;
    write_i = 1'b0; write_valid_i = 1'b0; write_data_i = '0;
    bd_we_i = 1'b0; bd_addr_i = '0; bd_wdata_i = '0;
    tick(); tick();
    reset_i = 1'b0;

    check("reset_grant", {63'd0, grant_o}, 64'd0);
    check("reset_read_valid", {63'd0, read_valid_o}, 64'd0);
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    check("reset_txn", {48'd0, txn_count_o}, 64'd0);
    check("reset_read_data", read_data_o, 64'd0);

    for (int i = 0; i < 4; i++) bd_write(8'(4 + i), 64'hA0 + 64'(i));
    for (int i = 16; i < 20; i++) bd_write(8'(i), 64'hDEAD);
    bd_check("bd_preload_w5", 8'd5, 64'hA1);

    // Read, size 9, grant in 3rd cycle after acceptance, 4 beats.
    for (int i = 0; i < 4; i++) exp_q.push_back(64'hA0 + 64'(i));
    request(32'h20, 4'd9, 1'b0);
    tick(); tick();
    check("rd_grant_c2", {63'd0, grant_o}, 64'd0);
    tick();
    check("rd_grant_c3", {63'd0, grant_o}, 64'd1);
    tick(); tick(); tick(); tick(); tick();
    req_i = 1'b0;
    check("rd_txn", {48'd0, txn_count_o}, 64'd1);
    check("rd_busy_done", {63'd0, busy_o}, 64'd0);
    check("rd_beat_count", 64'(rv_cnt), 64'd4);

    // Write, size 8, with one stall cycle.
    request(32'h40, 4'd8, 1'b1);
    tick(); tick(); tick(); tick();
    write_valid_i = 1'b1; write_data_i = 64'h11;
    tick();
    write_valid_i = 1'b0;
    tick();
    write_valid_i = 1'b1; write_data_i = 64'h22;
    check("wr_busy_last_beat", {63'd0, busy_o}, 64'd1);
    tick();
    req_i = 1'b0; write_valid_i = 1'b0;
    check("wr_busy_fall", {63'd0, busy_o}, 64'd0);
    check("wr_txn", {48'd0, txn_count_o}, 64'd2);
    bd_check("wr_word8", 8'd8, 64'h11);
    bd_check("wr_word9", 8'd9, 64'h22);
    check("wr_grant_count", 64'(grant_cnt), 64'd2);

    // Illegal requests: bad size, misaligned, overruns memory end.
    g0 = grant_cnt; e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      request(bad_addr[i], bad_size[i], 1'b0);
      tick();
      req_i = 1'b0;
      check("illegal_error_pulse", {63'd0, error_o}, 64'd1);
      tick();
      check("illegal_error_low", {63'd0, error_o}, 64'd0);
    end
    check("illegal_error_count", 64'(err_cnt - e0), 64'd3);
    check("illegal_no_grant", 64'(grant_cnt - g0), 64'd0);
    check("illegal_txn", {48'd0, txn_count_o}, 64'd2);

    // Abort a 4-beat read after the 2nd beat.
    r0 = rv_cnt;
    exp_q.push_back(64'hA0);
    exp_q.push_back(64'hA1);
    request(32'h20, 4'd9, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    req_i = 1'b0;
    tick();
    check("abort_idle", {63'd0, busy_o}, 64'd0);
    check("abort_beats", 64'(rv_cnt - r0), 64'd2);
    check("abort_txn", {48'd0, txn_count_o}, 64'd2);

    // Collision: backdoor 0xFF and bus 0x55 to word 32 in the same cycle.
    request(32'h100, 4'd3, 1'b1);
    tick(); tick(); tick(); tick();
    write_valid_i = 1'b1; write_data_i = 64'h55;
    bd_we_i = 1'b1; bd_addr_i = 8'd32; bd_wdata_i = 64'hFF;
    tick();
    write_valid_i = 1'b0; bd_we_i = 1'b0; req_i = 1'b0;
    bd_check("collision_word32", 8'd32, 64'h55);
    check("collision_txn", {48'd0, txn_count_o}, 64'd3);

    // Zero grant delay instance: grant in the cycle after acceptance.
    req0 = 1'b1; addr_i = 32'h20; size_i = 4'd3; write_i = 1'b0;
    tick();
    check("zd_grant", {63'd0, grant0}, 64'd1);
    tick();
    check("zd_read_valid", {63'd0, read_valid0}, 64'd1);
    check("zd_read_data", read_data0, 64'hA0);
    tick();
    req0 = 1'b0;
    check("zd_txn", {48'd0, txn0}, 64'd1);

    // Reset during WR_BEATS after one accepted beat.
    request(32'h80, 4'd9, 1'b1);
    tick(); tick(); tick(); tick();
    write_valid_i = 1'b1; write_data_i = 64'h77;
    tick();
    write_data_i = 64'h88; reset_i = 1'b1;
    tick();
    reset_i = 1'b0; req_i = 1'b0; write_valid_i = 1'b0;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_grant_err", {62'd0, grant_o, error_o}, 64'd0);
    check("rst_read_valid", {63'd0, read_valid_o}, 64'd0);
    check("rst_txn", {48'd0, txn_count_o}, 64'd0);
    check("rst_read_data", read_data_o, 64'd0);
    bd_check("rst_word16_kept", 8'd16, 64'h77);
    bd_check("rst_word17_untouched", 8'd17, 64'hDEAD);

    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
